// File: rtl/ask_bit_serializer.sv
// ask_bit_serializer
// ------------------
// Turns bytes into a serial keying stream for an ASK modulator. Each byte is
// sent as a frame: START (1), DATA_W data bits MSB first, STOP (0). Every bit
// lasts BIT_CYCLES clocks. A one-entry holding buffer lets the next byte be
// queued while a frame is in flight, so frames can run back to back.
//
// Parameters
//   BIT_CYCLES : clocks per transmitted bit (2..255)
//   DATA_W     : payload bits per frame
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous active-high reset
//   byte_in    : payload, sampled when byte_valid && byte_ready
//   byte_valid : upstream has a byte on byte_in
//   byte_ready : holding buffer is empty
//   bit_out    : registered keying bit (1 = carrier on)
//   bit_strobe : one-clock pulse on the first clock of every frame bit
//   busy       : FSM is not idle
//   frame_done : one-clock pulse on the last clock of STOP
module ask_bit_serializer #(
  parameter int BIT_CYCLES = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic                bit_out_q, bit_out_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end_s;
  logic                load_s;

  // Next-state, buffer handling and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load_s     = 1'b0;
    bit_end_s  = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (buf_full_q) begin
          state_d = ST_START;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          // A byte already waiting starts the next frame with no idle gap.
          if (buf_full_q) begin
            state_d = ST_START;
            load_s  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Unload only happens with the buffer full (byte_ready low), so it can
    // never collide with an accept.
    if (load_s) begin
      shreg_d    = buf_q;
      buf_full_d = 1'b0;
    end else if (byte_valid && !buf_full_q) begin
      buf_d      = byte_in;
      buf_full_d = 1'b1;
    end else begin
      buf_full_d = buf_full_q;
    end

    // Outputs are computed from next-state values so they register in step
    // with the state they describe.
    busy_d    = (state_d != ST_IDLE);
    strobe_d  = busy_d && (cnt_d == '0);
    done_d    = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
    bit_out_d = (state_d == ST_START) ||
                ((state_d == ST_DATA) && shreg_d[DATA_W-1]);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_out_q  <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_out_q  <= bit_out_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign byte_ready = ~buf_full_q;
  assign bit_out    = bit_out_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ask_bit_serializer.sv
// Self-checking bench for ask_bit_serializer: a default instance (8 clk/bit)
// and a fast instance (2 clk/bit). Expected waveforms come from the frame
// rule START/data MSB-first/STOP, each bit a fixed number of clocks.
module tb_ask_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready, bit_out, bit_strobe, busy, frame_done;
  logic [7:0] byte_in2;
  logic       byte_valid2;
  logic       byte_ready2, bit_out2, bit_strobe2, busy2, frame_done2;

  int errors = 0;
  int checks = 0;

  ask_bit_serializer dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .bit_out(bit_out), .bit_strobe(bit_strobe),
    .busy(busy), .frame_done(frame_done)
  );

  ask_bit_serializer #(.BIT_CYCLES(2), .DATA_W(8)) dut2 (
    .clk(clk), .reset(reset), .byte_in(byte_in2), .byte_valid(byte_valid2),
    .byte_ready(byte_ready2), .bit_out(bit_out2), .bit_strobe(bit_strobe2),
    .busy(busy2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit idx: 0 = START, 1..8 = data MSB first, 9 = STOP.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b1;
    else if (idx >= 9) return 1'b0;
    else return b[8-idx];
  endfunction

  task automatic test_reset();
    reset = 1'b1; byte_valid = 1'b1; byte_in = 8'hC3;
    byte_valid2 = 1'b0; byte_in2 = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    checks++; if (bit_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", bit_strobe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", byte_ready); end
    reset = 1'b0; byte_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || byte_ready !== 1'b1) begin
        errors++; $display("FAIL reset_valid_ignored busy=%b ready=%b exp busy=0 ready=1", busy, byte_ready);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] b);
    int nstr = 0;
    int nbusy = 0;
    byte_in = b; byte_valid = 1'b1;
    @(negedge clk);  // accept edge k
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL frame_accept_ready b=%h got=%b exp=0", b, byte_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_accept_busy b=%h got=%b exp=0", b, busy); end
    byte_valid = 1'b0; byte_in = 8'($urandom);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bit_strobe === 1'b1) nstr++;
      if (busy === 1'b1) nbusy++;
      checks++;
      if (bit_out !== exp_bit(b, (c-1)/8)) begin
        errors++; $display("FAIL frame_bit b=%h clk=%0d got=%b exp=%b", b, c, bit_out, exp_bit(b, (c-1)/8));
      end
      checks++;
      if (bit_strobe !== ((c-1) % 8 == 0)) begin
        errors++; $display("FAIL frame_strobe b=%h clk=%0d got=%b", b, c, bit_strobe);
      end
      checks++;
      if (frame_done !== (c == 80)) begin
        errors++; $display("FAIL frame_done b=%h clk=%0d got=%b", b, c, frame_done);
      end
      if (c == 1) begin
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL frame_unload_ready got=%b exp=1", byte_ready); end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bit_out !== 1'b0 || bit_strobe !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL frame_after busy=%b bit=%b str=%b done=%b exp all 0", busy, bit_out, bit_strobe, frame_done);
    end
    checks++; if (nstr != 10) begin errors++; $display("FAIL frame_strobe_count got=%0d exp=10", nstr); end
    checks++; if (nbusy != 80) begin errors++; $display("FAIL frame_busy_count got=%0d exp=80", nbusy); end
  endtask

  task automatic test_back_to_back();
    logic eb;
    byte_in = 8'hFF; byte_valid = 1'b1;
    @(negedge clk);  // edge k accepts 0xFF
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_k got=%b exp=0", byte_ready); end
    byte_in = 8'h00;  // ignored at k+1, accepted at k+2
    for (int c = 1; c <= 161; c++) begin
      @(negedge clk);
      eb = (c <= 72) || (c > 80 && c <= 88);
      checks++;
      if (bit_out !== eb) begin errors++; $display("FAIL b2b_bit clk=%0d got=%b exp=%b", c, bit_out, eb); end
      checks++;
      if (busy !== (c <= 160)) begin errors++; $display("FAIL b2b_busy clk=%0d got=%b", c, busy); end
      checks++;
      if (frame_done !== (c == 80 || c == 160)) begin errors++; $display("FAIL b2b_done clk=%0d got=%b", c, frame_done); end
      checks++;
      if (bit_strobe !== (c <= 160 && (c-1) % 8 == 0)) begin errors++; $display("FAIL b2b_strobe clk=%0d got=%b", c, bit_strobe); end
      if (c == 1) begin
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_1 got=%b exp=1", byte_ready); end
      end
      if (c == 2) begin
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_2 got=%b exp=0", byte_ready); end
        byte_valid = 1'b0;
      end
      if (c == 81) begin
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_81 got=%b exp=1", byte_ready); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    byte_in = 8'h5A; byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if (bit_out !== exp_bit(8'h5A, (c-1)/8) || frame_done !== 1'b0) begin
        errors++; $display("FAIL rst_mid_pre clk=%0d bit=%b done=%b exp bit=%b done=0", c, bit_out, frame_done, exp_bit(8'h5A, (c-1)/8));
      end
      if (c == 1) begin byte_in = 8'h3C; byte_valid = 1'b1; end
      if (c == 2) begin
        byte_valid = 1'b0;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_buffered got=%b exp=0", byte_ready); end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bit_out !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b0 || bit_strobe !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after bit=%b ready=%b busy=%b str=%b done=%b exp 0,1,0,0,0", bit_out, byte_ready, busy, bit_strobe, frame_done);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bit_out !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL rst_mid_discard clk=%0d busy=%b bit=%b done=%b exp all 0", c, busy, bit_out, frame_done);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] q[$];
    logic [9:0] bits;
    logic [7:0] got;
    int pos = -1;
    int naccept = 0;
    int nframes = 0;
    int guard = 0;
    for (int it = 0; it < 4000; it++) begin
      if (it >= 1500 && q.size() == 0 && pos < 0) break;
      @(negedge clk);
      // Decode the serial stream purely from bit_out timing.
      if (pos < 0 && bit_out === 1'b1) pos = 0;
      if (pos >= 0) begin
        if (pos % 8 == 0) bits[pos/8] = bit_out;
        else begin
          checks++;
          if (bit_out !== bits[pos/8]) begin errors++; $display("FAIL rnd_bit_stable pos=%0d got=%b exp=%b", pos, bit_out, bits[pos/8]); end
        end
        checks++;
        if (bit_strobe !== (pos % 8 == 0) || busy !== 1'b1 || frame_done !== (pos == 79)) begin
          errors++; $display("FAIL rnd_ctl pos=%0d str=%b busy=%b done=%b", pos, bit_strobe, busy, frame_done);
        end
        if (pos == 79) begin
          for (int j = 0; j < 8; j++) got[7-j] = bits[j+1];
          checks++;
          if (bits[0] !== 1'b1 || bits[9] !== 1'b0) begin errors++; $display("FAIL rnd_framing start=%b stop=%b exp 1,0", bits[0], bits[9]); end
          checks++;
          if (q.size() == 0) begin errors++; $display("FAIL rnd_extra_frame got=%h exp=none", got); end
          else if (got !== q[0]) begin errors++; $display("FAIL rnd_data got=%h exp=%h", got, q[0]); void'(q.pop_front()); end
          else void'(q.pop_front());
          nframes++;
          pos = -1;
        end else begin
          pos++;
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || bit_strobe !== 1'b0 || frame_done !== 1'b0) begin
          errors++; $display("FAIL rnd_idle busy=%b str=%b done=%b exp all 0", busy, bit_strobe, frame_done);
        end
      end
      // New stimulus; a byte counts as sent when valid meets ready at the next edge.
      if (it < 1500) begin
        byte_valid = ($urandom_range(0, 9) < 7);
        byte_in = 8'($urandom);
      end else begin
        byte_valid = 1'b0;
      end
      if (byte_valid && byte_ready === 1'b1) begin q.push_back(byte_in); naccept++; end
      guard = it;
    end
    byte_valid = 1'b0;
    checks++;
    if (q.size() != 0 || pos >= 0) begin errors++; $display("FAIL rnd_drain pending=%0d pos=%0d after %0d cycles exp 0,-1", q.size(), pos, guard); end
    checks++;
    if (nframes != naccept || naccept < 10) begin errors++; $display("FAIL rnd_count frames=%0d accepted=%0d", nframes, naccept); end
  endtask

  task automatic test_bc2();
    int nstr = 0;
    byte_in2 = 8'h01; byte_valid2 = 1'b1;
    @(negedge clk);
    byte_valid2 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bit_strobe2 === 1'b1) nstr++;
      checks++;
      if (bit_out2 !== (c <= 2 || c == 17 || c == 18)) begin errors++; $display("FAIL bc2_bit clk=%0d got=%b", c, bit_out2); end
      checks++;
      if (bit_strobe2 !== ((c-1) % 2 == 0) || busy2 !== 1'b1 || frame_done2 !== (c == 20)) begin
        errors++; $display("FAIL bc2_ctl clk=%0d str=%b busy=%b done=%b", c, bit_strobe2, busy2, frame_done2);
      end
    end
    @(negedge clk);
    checks++; if (busy2 !== 1'b0 || bit_out2 !== 1'b0) begin errors++; $display("FAIL bc2_after busy=%b bit=%b exp 0,0", busy2, bit_out2); end
    checks++; if (nstr != 10) begin errors++; $display("FAIL bc2_strobe_count got=%0d exp=10", nstr); end
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
    byte_valid2 = 1'b0; byte_in2 = 8'h00;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'($urandom));
    test_frame(8'($urandom));
    test_frame(8'h00);
    test_back_to_back();
    test_reset_midframe();
    test_random_stream();
    test_bc2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
